tea_host_ctrl: RTL and testbench
================================

// Module: tea_host_ctrl
// PURPOSE
//  Initiator for the TEA core register interface. Accepts one 64-bit block, mode and key over a
//  valid/ready stream, and programs key/data/control words into the TEA core. Waits for completion,
//  reads both result words back, and returns them on an output valid/ready stream.
//  Sits between a streaming datapath and the register-mapped tea core; no software involvement.
// PARAMETERS
//  WORD_SIZE  32  width of one TEA word / core data bus
//  TIMEOUT    64  max cycles in each wait state before the block aborts with m_err
// PORTS
//  i_clk         in   1            clock
//  i_rstn        in   1            async active-low reset
//  s_valid       in   1            request valid
//  s_ready       out  1            request accepted when s_valid && s_ready
//  s_data        in   2*WORD_SIZE  [2W-1:W]=v0, [W-1:0]=v1
//  s_mode        in   1            0=encrypt (CTRL_ENC), 1=decrypt (CTRL_DEC)
//  s_key         in   4*WORD_SIZE  [4W-1:3W]=k0 .. [W-1:0]=k3
//  s_key_upd     in   1            1=write key regs for this request; 0=reuse key already in core
//  m_valid       out  1            result valid
//  m_ready       in   1            result consumed when m_valid && m_ready
//  m_data        out  2*WORD_SIZE  same packing as s_data (result v0,v1)
//  m_err         out  1            qualifies m_valid: 1=timeout abort, m_data=0
//  o_tea_data    out  WORD_SIZE    write data to core
//  o_tea_addr    out  4            core register address
//  o_tea_we      out  1            core write enable
//  i_tea_data    in   WORD_SIZE    core read data (registered in core; valid 1 cycle after addr with we=0)
//  i_tea_ready   in   1            core idle/done flag
// BEHAVIOUR
//  Reset: all outputs 0 except s_ready=1; FSM=IDLE; timeout counter=0; captured request cleared.
//  Core map: 0/1 data, 2..5 key k0..k3, 6 control, 7/8 result.
//  IDLE: s_ready=1, o_tea_we=0, o_tea_addr=0. On handshake, register s_data/s_mode/s_key/s_key_upd,
//   s_ready->0. If s_key_upd, go WR_KEY; otherwise go WR_DATA.
//  WR_KEY: 4 cycles, we=1, addr 2,3,4,5 with k0..k3.
//  WR_DATA: 2 cycles, addr 0=v0, addr 1=v1.
//  WR_CTRL: 1 cycle, addr 6 = CTRL_ENC or CTRL_DEC per mode.
//  WAIT_BUSY: we=0, addr=7. Exit to WAIT_DONE on first cycle i_tea_ready==0.
//  WAIT_DONE: we=0, addr=7. Exit to RD0 on first cycle i_tea_ready==1.
//  Timeout counter: cleared on entry to each wait state; increments every cycle in that state.
//   If it reaches TIMEOUT-1 without the exit condition, go to OUT with m_err=1 and m_data=0.
//  RD0: we=0, addr=7. RD1: addr=8, capture i_tea_data as v0. RD2: capture i_tea_data as v1.
//  OUT: m_valid=1, m_data/m_err held stable until m_ready. On handshake -> IDLE (m_valid=0, s_ready=1).
//  o_tea_we asserts only in WR_* states; never writes addr 7/8.
//  Latency from s handshake to m_valid (no key): 3 writes + busy/done waits + 3 reads + 1.
//  m_valid and s_ready are never both 1. A new request is not accepted until the result is consumed.
//  Reset mid-operation: FSM returns to IDLE immediately; the in-flight result is dropped.
//   The core resets on the same i_rstn.
//  The held key is only valid once at least one s_key_upd=1 request has completed its key writes.
// STRUCTURE
//  Core addresses, CTRL_NONE/ENC/DEC codes and the FSM state enum live in the shared tea package
//   used by both tea and tea_host_ctrl.
//  One FSM plus one timeout counter, all in this module; no sub-module.
// TESTING (bench instantiates tea_host_ctrl + tea core, WORD_SIZE=32)
//  1 enc: key=0, data=0, key_upd=1, mode=0 -> m_data={32'h41EA3A0A,32'h94BAA940}, m_err=0.
//  2 dec: previous result, key_upd=0, mode=1 -> m_data=0.
//    Monitor confirms no writes to addr 2..5 in this request.
//  3 backpressure: hold m_ready=0 for 10 cycles after m_valid -> m_data stable, s_ready=0 throughout.
//    Release -> exactly one handshake, then s_ready=1.
//  4 timeout: replace core with stub holding i_tea_ready=1 -> m_valid with m_err=1, m_data=0
//    exactly TIMEOUT cycles after WAIT_BUSY entry.
//  5 reset: assert i_rstn=0 during WAIT_DONE -> all outputs at reset values, s_ready=1.
//    Next request (key=0, data=0) yields the vector from scenario 1.
//  6 bus trace: key_upd=1 request -> we/addr sequence 2,3,4,5,0,1,6 on consecutive cycles,
//    then reads of 7 and 8.

Source files
------------

// File: rtl/tea_host_ctrl_pkg.sv
// tea_host_ctrl_pkg: shared TEA core register map, control codes and host FSM states
package tea_host_ctrl_pkg;

    localparam logic [3:0] ADDR_V0   = 4'd0;
    localparam logic [3:0] ADDR_V1   = 4'd1;
    localparam logic [3:0] ADDR_K0   = 4'd2;
    localparam logic [3:0] ADDR_CTRL = 4'd6;
    localparam logic [3:0] ADDR_RES0 = 4'd7;
    localparam logic [3:0] ADDR_RES1 = 4'd8;

    localparam int CTRL_NONE = 0;
    localparam int CTRL_ENC  = 1;
    localparam int CTRL_DEC  = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_DATA,
        S_WR_CTRL,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_OUT
    } state_t;

endpackage

// File: rtl/tea_host_ctrl.sv
// tea_host_ctrl: streams one block through the register-mapped TEA core and returns the result
module tea_host_ctrl
    import tea_host_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [2*WORD_SIZE-1:0] s_data,
    input  logic                   s_mode,
    input  logic [4*WORD_SIZE-1:0] s_key,
    input  logic                   s_key_upd,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*WORD_SIZE-1:0] m_data,
    output logic                   m_err,
    output logic [WORD_SIZE-1:0]   o_tea_data,
    output logic [3:0]             o_tea_addr,
    output logic                   o_tea_we,
    input  logic [WORD_SIZE-1:0]   i_tea_data,
    input  logic                   i_tea_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 state, next;
    logic [CW-1:0]          cnt;
    logic [2*WORD_SIZE-1:0] data_q, res;
    logic [4*WORD_SIZE-1:0] key_q;
    logic                   mode_q, err, timeout;

    assign timeout = (cnt == CW'(TIMEOUT - 1));
    assign m_data  = m_valid ? res : '0;
    assign m_err   = m_valid & err;

    // state register; cnt restarts on every state change and serves as word index and wait timer
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next;
            cnt   <= (next != state || state == S_IDLE || state == S_OUT) ? '0 : cnt + 1'b1;
        end
    end

    // request capture and result assembly; a wait timeout forces a zero result with err set
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
            res    <= '0;
            err    <= 1'b0;
        end else begin
            if (state == S_IDLE && s_valid) begin
                data_q <= s_data;
                key_q  <= s_key;
                mode_q <= s_mode;
                err    <= 1'b0;
            end
            if (state == S_RD1) res[2*WORD_SIZE-1:WORD_SIZE] <= i_tea_data;
            if (state == S_RD2) res[WORD_SIZE-1:0] <= i_tea_data;
            if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && next == S_OUT) begin
                res <= '0;
                err <= 1'b1;
            end
        end
    end

    // next-state and bus/handshake outputs; writes only happen in the WR_* states
    always_comb begin
        next       = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        o_tea_we   = 1'b0;
        o_tea_addr = 4'd0;
        o_tea_data = '0;
        case (state)
            S_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) next = s_key_upd ? S_WR_KEY : S_WR_DATA;
            end
            S_WR_KEY: begin
                o_tea_we   = 1'b1;
                o_tea_addr = ADDR_K0 + {2'b00, cnt[1:0]};
                o_tea_data = key_q[(3 - int'(cnt[1:0]))*WORD_SIZE +: WORD_SIZE];
                if (cnt[1:0] == 2'd3) next = S_WR_DATA;
            end
            S_WR_DATA: begin
                o_tea_we   = 1'b1;
                o_tea_addr = ADDR_V0 + {3'b000, cnt[0]};
                o_tea_data = cnt[0] ? data_q[WORD_SIZE-1:0] : data_q[2*WORD_SIZE-1:WORD_SIZE];
                if (cnt[0]) next = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                o_tea_we   = 1'b1;
                o_tea_addr = ADDR_CTRL;
                o_tea_data = mode_q ? WORD_SIZE'(CTRL_DEC) : WORD_SIZE'(CTRL_ENC);
                next       = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                o_tea_addr = ADDR_RES0;
                next = !i_tea_ready ? S_WAIT_DONE : timeout ? S_OUT : S_WAIT_BUSY;
            end
            S_WAIT_DONE: begin
                o_tea_addr = ADDR_RES0;
                next = i_tea_ready ? S_RD0 : timeout ? S_OUT : S_WAIT_DONE;
            end
            S_RD0: begin
                o_tea_addr = ADDR_RES0;
                next       = S_RD1;
            end
            S_RD1: begin
                o_tea_addr = ADDR_RES1;
                next       = S_RD2;
            end
            S_RD2: begin
                o_tea_addr = ADDR_RES1;
                next       = S_OUT;
            end
            S_OUT: begin
                m_valid = 1'b1;
                if (m_ready) next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tea_host_ctrl.sv
// tb_tea_host_ctrl: drives tea_host_ctrl against a behavioural TEA core and a TEA reference model
module tb_tea_host_ctrl;
    import tea_host_ctrl_pkg::*;

    localparam int W    = 32;
    localparam int TO   = 64;
    localparam int BUSY = 32;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           s_valid = 1'b0, s_ready;
    logic [2*W-1:0] s_data = '0;
    logic           s_mode = 1'b0;
    logic [4*W-1:0] s_key = '0;
    logic           s_key_upd = 1'b0;
    logic           m_valid, m_ready = 1'b0, m_err;
    logic [2*W-1:0] m_data;
    logic [W-1:0]   tea_wdata, tea_rdata;
    logic [3:0]     tea_addr;
    logic           tea_we, tea_ready;

    int             n_checks = 0, n_fail = 0;
    int             hs_cnt = 0, both_cnt = 0, badwr_cnt = 0;
    logic [36:0]    trace[$];
    bit             stable_bad;
    logic [127:0]   held_key = '0;

    always #5 clk = ~clk;

    tea_host_ctrl #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .s_key(s_key), .s_key_upd(s_key_upd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
        .o_tea_data(tea_wdata), .o_tea_addr(tea_addr), .o_tea_we(tea_we),
        .i_tea_data(tea_rdata), .i_tea_ready(tea_ready)
    );

    function automatic logic [63:0] tea_ref(input bit dec, input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = v[63:32];
        z = v[31:0];
        s = dec ? 32'hC6EF3720 : 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (!dec) begin
                s += 32'h9E3779B9;
                y += ((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]);
                z += ((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]);
            end else begin
                z -= ((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]);
                y -= ((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]);
                s -= 32'h9E3779B9;
            end
        end
        return {y, z};
    endfunction

    // behavioural TEA core: register file, busy for BUSY cycles after a control write, registered reads
    logic [31:0] regs [16];
    int          busy;
    logic        core_ready;
    bit          stub = 1'b0;
    logic [63:0] core_res;
    assign core_res  = tea_ref(regs[6] == 32'(CTRL_DEC), {regs[0], regs[1]}, {regs[2], regs[3], regs[4], regs[5]});
    assign tea_ready = stub | core_ready;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            busy       <= 0;
            core_ready <= 1'b1;
            tea_rdata  <= '0;
        end else begin
            tea_rdata <= regs[tea_addr];
            if (tea_we) regs[tea_addr] <= tea_wdata;
            if (tea_we && tea_addr == 4'd6 && (tea_wdata == 32'(CTRL_ENC) || tea_wdata == 32'(CTRL_DEC))) begin
                busy       <= BUSY;
                core_ready <= 1'b0;
            end else if (busy > 1) begin
                busy <= busy - 1;
            end else if (busy == 1) begin
                busy       <= 0;
                core_ready <= 1'b1;
                regs[7]    <= core_res[63:32];
                regs[8]    <= core_res[31:0];
            end
        end
    end

    // protocol monitors
    always @(posedge clk) if (rstn && m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    always @(negedge clk) begin
        if (m_valid && s_ready) both_cnt <= both_cnt + 1;
        if (tea_we && tea_addr >= 4'd7) badwr_cnt <= badwr_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic run_req(input logic [63:0] d, input bit mode, input logic [127:0] k, input bit upd,
                           input int hold, output logic [63:0] r, output logic e, output bit ok);
        int n;
        ok = 1'b0;
        r = '0;
        e = 1'b0;
        trace.delete();
        stable_bad = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_mode = mode; s_key = k; s_key_upd = upd;
        n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept: s_ready=%b required 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; s_data = {$urandom, $urandom}; s_key = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!m_valid && n < 400) begin
            trace.push_back({tea_we, tea_addr, tea_wdata});
            @(negedge clk);
            n++;
        end
        if (!m_valid) begin
            n_checks++; n_fail++;
            $display("FAIL result_wait: m_valid=%b required 1 within 400 cycles", m_valid);
            return;
        end
        r = m_data;
        e = m_err;
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (m_data !== r || m_err !== e || m_valid !== 1'b1 || s_ready !== 1'b0) stable_bad = 1'b1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        if (upd) held_key = k;
    endtask

    task automatic test_reset();
        logic [103:0] got;
        repeat (3) @(negedge clk);
        got = {s_ready, m_valid, m_err, tea_we, tea_addr, tea_wdata, m_data};
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 64'd0}) begin
            n_fail++; $display("FAIL reset_outputs: got %h required %h", got, {1'b1, 103'd0});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({s_ready, m_valid, tea_we} !== 3'b100) begin
            n_fail++; $display("FAIL reset_idle: s_ready/m_valid/we=%b required 100", {s_ready, m_valid, tea_we});
        end
    endtask

    task automatic test_enc_vector(output logic [63:0] res);
        logic [63:0] r; logic e; bit ok;
        run_req(64'd0, 1'b0, 128'd0, 1'b1, 0, r, e, ok);
        res = r;
        if (ok) begin
            n_checks++;
            if (r !== 64'h41EA3A0A94BAA940) begin
                n_fail++; $display("FAIL enc_vector: m_data=%h required 41ea3a0a94baa940", r);
            end
            n_checks++;
            if (e !== 1'b0) begin n_fail++; $display("FAIL enc_err: m_err=%b required 0", e); end
        end
    endtask

    task automatic test_dec(input logic [63:0] prev);
        logic [63:0] r; logic e; bit ok; int kw;
        run_req(prev, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, r, e, ok);
        if (ok) begin
            n_checks++;
            if (r !== 64'd0 || e !== 1'b0) begin
                n_fail++; $display("FAIL dec_vector: m_data=%h m_err=%b required 0 and 0", r, e);
            end
            kw = 0;
            foreach (trace[i]) if (trace[i][36] && trace[i][35:32] >= 4'd2 && trace[i][35:32] <= 4'd5) kw++;
            n_checks++;
            if (kw != 0) begin n_fail++; $display("FAIL dec_no_key_writes: key writes=%0d required 0", kw); end
        end
    endtask

    task automatic test_bus_trace();
        logic [63:0] d, r; logic [127:0] k; logic e; bit ok, bad; logic [36:0] ex[7]; int j;
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        ex[0] = {1'b1, 4'd2, k[127:96]};
        ex[1] = {1'b1, 4'd3, k[95:64]};
        ex[2] = {1'b1, 4'd4, k[63:32]};
        ex[3] = {1'b1, 4'd5, k[31:0]};
        ex[4] = {1'b1, 4'd0, d[63:32]};
        ex[5] = {1'b1, 4'd1, d[31:0]};
        ex[6] = {1'b1, 4'd6, 32'(CTRL_ENC)};
        run_req(d, 1'b0, k, 1'b1, 0, r, e, ok);
        if (ok) begin
            bad = 1'b0;
            for (int i = 0; i < 7; i++) if (i >= trace.size() || trace[i] !== ex[i]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++; $display("FAIL trace_writes: first entry %h required %h (size %0d)", trace[0], ex[0], trace.size());
            end
            bad = 1'b0;
            j = 7;
            while (j < trace.size() && trace[j][35:32] == 4'd7) j++;
            if (j >= trace.size() || j < 10 || trace[j][35:32] != 4'd8) bad = 1'b1;
            for (int i = 7; i < trace.size(); i++) if (trace[i][36]) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++; $display("FAIL trace_reads: addr-7 run ends at %0d of %0d, required read of 7 then 8 with we=0", j, trace.size());
            end
            n_checks++;
            if (r !== tea_ref(1'b0, d, k) || e !== 1'b0) begin
                n_fail++; $display("FAIL trace_result: m_data=%h required %h", r, tea_ref(1'b0, d, k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, r; logic e; bit ok; int h0;
        d = {$urandom, $urandom};
        h0 = hs_cnt;
        run_req(d, 1'b0, 128'd0, 1'b0, 10, r, e, ok);
        if (ok) begin
            n_checks++;
            if (stable_bad) begin n_fail++; $display("FAIL bp_stable: outputs changed while m_ready=0"); end
            n_checks++;
            if (r !== tea_ref(1'b0, d, held_key)) begin
                n_fail++; $display("FAIL bp_result: m_data=%h required %h", r, tea_ref(1'b0, d, held_key));
            end
            repeat (2) @(negedge clk);
            n_checks++;
            if (hs_cnt - h0 != 1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_release: handshakes=%0d s_ready=%b m_valid=%b required 1 1 0", hs_cnt - h0, s_ready, m_valid);
            end
        end
    endtask

    task automatic test_timeout();
        logic [63:0] r; logic e; bit ok;
        stub = 1'b1;
        run_req({$urandom, $urandom}, 1'b0, 128'd0, 1'b0, 0, r, e, ok);
        stub = 1'b0;
        if (ok) begin
            n_checks++;
            if (e !== 1'b1 || r !== 64'd0) begin
                n_fail++; $display("FAIL timeout_err: m_err=%b m_data=%h required 1 and 0", e, r);
            end
            n_checks++;
            if (trace.size() != 3 + TO) begin
                n_fail++; $display("FAIL timeout_latency: %0d cycles after wait entry, required %0d", trace.size() - 3, TO);
            end
        end
        repeat (BUSY) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; logic e; bit ok; logic [103:0] got;
        @(negedge clk);
        s_valid = 1'b1; s_data = {$urandom, $urandom}; s_mode = 1'b0; s_key_upd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if ({tea_we, tea_addr, m_valid, s_ready} !== {1'b0, 4'd7, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mid_wait: we/addr/m_valid/s_ready=%b required 0011100", {tea_we, tea_addr, m_valid, s_ready});
        end
        rstn = 1'b0;
        #1;
        got = {s_ready, m_valid, m_err, tea_we, tea_addr, tea_wdata, m_data};
        n_checks++;
        if (got !== {1'b1, 103'd0}) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required %h", got, {1'b1, 103'd0});
        end
        @(negedge clk);
        rstn = 1'b1;
        held_key = '0;
        run_req(64'd0, 1'b0, 128'd0, 1'b1, 0, r, e, ok);
        if (ok) begin
            n_checks++;
            if (r !== 64'h41EA3A0A94BAA940 || e !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_vector: m_data=%h m_err=%b required 41ea3a0a94baa940 0", r, e);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] d, r, ex; logic [127:0] k; logic e; bit ok, mode, upd;
        for (int i = 0; i < 8; i++) begin
            d    = {$urandom, $urandom};
            k    = {$urandom, $urandom, $urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            upd  = 1'($urandom_range(0, 1));
            ex   = tea_ref(mode, d, upd ? k : held_key);
            run_req(d, mode, k, upd, $urandom_range(0, 3), r, e, ok);
            if (ok) begin
                n_checks++;
                if (r !== ex || e !== 1'b0) begin
                    n_fail++; $display("FAIL random_%0d: m_data=%h m_err=%b required %h 0 (mode %b upd %b)", i, r, e, ex, mode, upd);
                end
            end
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL both_valid_ready: cycles=%0d required 0", both_cnt); end
        n_checks++;
        if (badwr_cnt != 0) begin n_fail++; $display("FAIL result_writes: cycles=%0d required 0", badwr_cnt); end
    endtask

    initial begin
        logic [63:0] enc_res;
        test_reset();
        test_enc_vector(enc_res);
        test_dec(enc_res);
        test_bus_trace();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
